stage_memory: RTL and testbench

//  - MEM stage of the 5-stage RV32I pipeline. Sits between the EX/MEM boundary (ex_* inputs) and stage_writeback (mem_* outputs).
//  - Performs loads and stores over a req/gnt/rvalid data bus, with byte-lane alignment and load sign extension.
//  - Stalls the pipeline while an access is outstanding. Registers the result bundle that writeback consumes.

---
 rtl/core_pkg.sv | 39 +++
 rtl/mem_align.sv | 60 ++++++
 rtl/stage_memory.sv | 157 +++++++++++++++
 tb/tb_stage_memory.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared pipeline constants: funct3 access encodings, writeback source
// selects and the MEM-stage bus FSM state type.
package core_pkg;

    // Load access encodings (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store access encodings (funct3)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Writeback result source selects
    localparam logic [1:0] ALU_RESULT = 2'b00;
    localparam logic [1:0] MEM_TO_REG = 2'b01;
    localparam logic [1:0] PC_PLUS    = 2'b10;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_GNT    = 2'b01,
        WAIT_RVALID = 2'b10
    } mem_state_t;

    // Access size is funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for the MEM stage: store byte enables and lane
// replication, load lane extraction with sign/zero extension.
module mem_align
    import core_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign misaligned = is_misaligned(funct3[1:0], addr_lo);
    assign byte_s     = rdata[{addr_lo, 3'b000} +: 8];
    assign half_s     = rdata[{addr_lo[1], 4'b0000} +: 16];

    // Store side: enable the addressed lanes and replicate data across the word
    always_comb begin
        be    = 4'h0;
        wdata = 32'h0000_0000;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            2'b10: begin
                be    = 4'hF;
                wdata = store_data;
            end
            default: begin
                be    = 4'h0;
                wdata = 32'h0000_0000;
            end
        endcase
    end

    // Load side: pick the addressed lane and extend it to 32 bits
    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
            F3_LH:   load_data = {{16{half_s[15]}}, half_s};
            F3_LW:   load_data = rdata;
            F3_LBU:  load_data = {24'h00_0000, byte_s};
            F3_LHU:  load_data = {16'h0000, half_s};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// MEM stage of the RV32I pipeline: issues loads/stores on the req/gnt/rvalid
// bus, stalls upstream while an access is outstanding and registers the
// result bundle for writeback.
module stage_memory
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic [1:0]      ex_result_src,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_write_data,
    input  logic [XLEN-1:0] ex_instr_addr_plus,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_mem_rd_enable,
    input  logic            ex_mem_wr_enable,
    input  logic            ex_regfile_wr_enable,
    output logic [4:0]      mem_rd,
    output logic [1:0]      mem_result_src,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_read_data,
    output logic [XLEN-1:0] mem_instr_addr_plus,
    output logic            mem_regfile_wr_enable,
    output logic            mem_stall,
    output logic            mem_misaligned,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [3:0]      dbus_be,
    output logic [XLEN-1:0] dbus_wdata,
    input  logic            dbus_gnt,
    input  logic            dbus_rvalid,
    input  logic [XLEN-1:0] dbus_rdata
);

    mem_state_t  state_r;
    mem_state_t  next_state_s;
    logic        mem_op_s;
    logic        misaligned_s;
    logic        issue_s;
    logic        is_load_s;
    logic        req_s;
    logic        stall_s;
    logic        done_s;
    logic [31:0] load_data_s;

    assign mem_op_s  = ex_valid & (ex_mem_rd_enable | ex_mem_wr_enable);
    assign issue_s   = mem_op_s & ~misaligned_s;
    assign is_load_s = ex_mem_rd_enable;

    mem_align u_align (
        .funct3     (ex_funct3),
        .addr_lo    (ex_alu_result[1:0]),
        .store_data (ex_write_data),
        .rdata      (dbus_rdata),
        .be         (dbus_be),
        .wdata      (dbus_wdata),
        .load_data  (load_data_s),
        .misaligned (misaligned_s)
    );

    // Request is gated by rst so it drops the moment reset is asserted.
    assign dbus_req  = req_s & ~rst;
    assign dbus_we   = req_s & ~is_load_s;
    assign dbus_addr = {ex_alu_result[XLEN-1:2], 2'b00};
    assign mem_stall = stall_s & ~rst;

    // Bus FSM next state, request, stall and completion decode
    always_comb begin
        next_state_s = state_r;
        req_s        = 1'b0;
        stall_s      = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (issue_s) begin
                    req_s = 1'b1;
                    if (dbus_gnt) begin
                        if (is_load_s) begin
                            next_state_s = WAIT_RVALID;
                            stall_s      = 1'b1;
                        end else begin
                            done_s = 1'b1;
                        end
                    end else begin
                        next_state_s = WAIT_GNT;
                        stall_s      = 1'b1;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT_GNT: begin
                req_s = 1'b1;
                if (dbus_gnt) begin
                    if (is_load_s) begin
                        next_state_s = WAIT_RVALID;
                        stall_s      = 1'b1;
                    end else begin
                        next_state_s = IDLE;
                        done_s       = 1'b1;
                    end
                end else begin
                    stall_s = 1'b1;
                end
            end
            WAIT_RVALID: begin
                if (dbus_rvalid) begin
                    next_state_s = IDLE;
                    done_s       = 1'b1;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Bus FSM state register; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Writeback bundle: bubble while stalled, otherwise capture the retiring op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd                <= 5'd0;
            mem_result_src        <= 2'b00;
            mem_alu_result        <= '0;
            mem_read_data         <= '0;
            mem_instr_addr_plus   <= '0;
            mem_regfile_wr_enable <= 1'b0;
            mem_misaligned        <= 1'b0;
        end else if (stall_s) begin
            mem_regfile_wr_enable <= 1'b0;
            mem_misaligned        <= 1'b0;
        end else begin
            mem_rd                <= ex_rd;
            mem_result_src        <= ex_result_src;
            mem_alu_result        <= ex_alu_result;
            mem_instr_addr_plus   <= ex_instr_addr_plus;
            mem_read_data         <= (done_s && is_load_s) ? load_data_s : 32'h0000_0000;
            mem_regfile_wr_enable <= ex_valid & ex_regfile_wr_enable & ~(mem_op_s & misaligned_s);
            mem_misaligned        <= mem_op_s & misaligned_s;
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Scoreboard bench for stage_memory: expected writeback bundles are queued as
// each instruction is driven and compared when the stage retires them.
module tb_stage_memory;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_result_src;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_write_data;
    logic [31:0] ex_instr_addr_plus;
    logic [2:0]  ex_funct3;
    logic        ex_mem_rd_enable;
    logic        ex_mem_wr_enable;
    logic        ex_regfile_wr_enable;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_result_src;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_read_data;
    logic [31:0] mem_instr_addr_plus;
    logic        mem_regfile_wr_enable;
    logic        mem_stall;
    logic        mem_misaligned;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] data;
        logic [31:0] pc4;
        logic        wen;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [31:0] pc_v    = 32'h0000_1000;

    stage_memory dut (
        .clk                   (clk),
        .rst                   (rst),
        .ex_valid              (ex_valid),
        .ex_rd                 (ex_rd),
        .ex_result_src         (ex_result_src),
        .ex_alu_result         (ex_alu_result),
        .ex_write_data         (ex_write_data),
        .ex_instr_addr_plus    (ex_instr_addr_plus),
        .ex_funct3             (ex_funct3),
        .ex_mem_rd_enable      (ex_mem_rd_enable),
        .ex_mem_wr_enable      (ex_mem_wr_enable),
        .ex_regfile_wr_enable  (ex_regfile_wr_enable),
        .mem_rd                (mem_rd),
        .mem_result_src        (mem_result_src),
        .mem_alu_result        (mem_alu_result),
        .mem_read_data         (mem_read_data),
        .mem_instr_addr_plus   (mem_instr_addr_plus),
        .mem_regfile_wr_enable (mem_regfile_wr_enable),
        .mem_stall             (mem_stall),
        .mem_misaligned        (mem_misaligned),
        .dbus_req              (dbus_req),
        .dbus_we               (dbus_we),
        .dbus_addr             (dbus_addr),
        .dbus_be               (dbus_be),
        .dbus_wdata            (dbus_wdata),
        .dbus_gnt              (dbus_gnt),
        .dbus_rvalid           (dbus_rvalid),
        .dbus_rdata            (dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ex();
        ex_valid             = 1'b0;
        ex_mem_rd_enable     = 1'b0;
        ex_mem_wr_enable     = 1'b0;
        ex_regfile_wr_enable = 1'b0;
    endtask

    task automatic set_op(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] d, input logic rden, input logic wren,
                          input logic rwe, input logic [1:0] src);
        pc_v                 = pc_v + 32'd4;
        ex_valid             = 1'b1;
        ex_rd                = rd;
        ex_funct3            = f3;
        ex_alu_result        = addr;
        ex_write_data        = d;
        ex_mem_rd_enable     = rden;
        ex_mem_wr_enable     = wren;
        ex_regfile_wr_enable = rwe;
        ex_result_src        = src;
        ex_instr_addr_plus   = pc_v;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] alu,
                            input logic [31:0] data, input logic wen, input logic mis);
        exp_t e;
        e.rd = rd; e.src = src; e.alu = alu; e.data = data;
        e.pc4 = pc_v; e.wen = wen; e.mis = mis;
        exp_q.push_back(e);
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input int gnt_delay, input logic [31:0] exp_data);
        set_op(rd, f3, addr, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 2'b01);
        push_exp(rd, 2'b01, addr, exp_data, 1'b1, 1'b0);
        for (int i = 0; i < gnt_delay; i++) begin
            dbus_gnt = 1'b0;
            #1;
            check_eq("ld_wait_req", 32'(dbus_req), 32'd1);
            check_eq("ld_wait_stall", 32'(mem_stall), 32'd1);
            step();
        end
        dbus_gnt = 1'b1;
        #1;
        check_eq("ld_req", 32'(dbus_req), 32'd1);
        check_eq("ld_we", 32'(dbus_we), 32'd0);
        check_eq("ld_addr", dbus_addr, addr & 32'hFFFF_FFFC);
        check_eq("ld_gnt_stall", 32'(mem_stall), 32'd1);
        step();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = rdata;
        #1;
        check_eq("ld_rv_req", 32'(dbus_req), 32'd0);
        check_eq("ld_rv_stall", 32'(mem_stall), 32'd0);
        step();
        dbus_rvalid = 1'b0;
        idle_ex();
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d,
                            input int gnt_delay, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        set_op(5'd0, f3, addr, d, 1'b0, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < gnt_delay; i++) begin
            dbus_gnt = 1'b0;
            #1;
            check_eq("st_wait_req", 32'(dbus_req), 32'd1);
            check_eq("st_wait_be", 32'(dbus_be), 32'(exp_be));
            check_eq("st_wait_wdata", dbus_wdata, exp_wdata);
            check_eq("st_wait_stall", 32'(mem_stall), 32'd1);
            step();
        end
        dbus_gnt = 1'b1;
        #1;
        check_eq("st_req", 32'(dbus_req), 32'd1);
        check_eq("st_we", 32'(dbus_we), 32'd1);
        check_eq("st_addr", dbus_addr, addr & 32'hFFFF_FFFC);
        check_eq("st_be", 32'(dbus_be), 32'(exp_be));
        check_eq("st_wdata", dbus_wdata, exp_wdata);
        check_eq("st_gnt_stall", 32'(mem_stall), 32'd0);
        step();
        dbus_gnt = 1'b0;
        idle_ex();
    endtask

    // Scoreboard: every non-bubble retirement must match the oldest queued entry
    always @(negedge clk) begin
        if (!rst && (mem_regfile_wr_enable || mem_misaligned)) begin
            if (exp_q.size() == 0) begin
                check_eq("wb_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("wb_rd", 32'(mem_rd), 32'(e.rd));
                check_eq("wb_wen", 32'(mem_regfile_wr_enable), 32'(e.wen));
                check_eq("wb_mis", 32'(mem_misaligned), 32'(e.mis));
                check_eq("wb_src", 32'(mem_result_src), 32'(e.src));
                check_eq("wb_alu", mem_alu_result, e.alu);
                check_eq("wb_pc4", mem_instr_addr_plus, e.pc4);
                if (e.src == 2'b01 && !e.mis) begin
                    check_eq("wb_data", mem_read_data, e.data);
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'h0000_0000;
        ex_rd = 5'd0; ex_funct3 = 3'd0; ex_alu_result = 32'd0; ex_write_data = 32'd0;
        ex_result_src = 2'b00; ex_instr_addr_plus = 32'd0;
        idle_ex();
        // A valid load held during reset must not raise a request
        set_op(5'd1, 3'b010, 32'h0000_0040, 32'd0, 1'b1, 1'b0, 1'b1, 2'b01);
        step();
        step();
        check_eq("rst_req", 32'(dbus_req), 32'd0);
        check_eq("rst_stall", 32'(mem_stall), 32'd0);
        check_eq("rst_wen", 32'(mem_regfile_wr_enable), 32'd0);
        check_eq("rst_mis", 32'(mem_misaligned), 32'd0);
        check_eq("rst_rd", 32'(mem_rd), 32'd0);
        idle_ex();
        rst = 1'b0;
        step();

        // LW with same-cycle grant and rvalid one cycle later
        do_load(5'd5, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
        step();
        // Byte loads: signed and unsigned from lane 3
        do_load(5'd6, 3'b000, 32'h0000_0103, 32'h80FF_0000, 0, 32'hFFFF_FF80);
        do_load(5'd7, 3'b100, 32'h0000_0103, 32'h80FF_0000, 1, 32'h0000_0080);
        // Halfword loads from upper half
        do_load(5'd8, 3'b001, 32'h0000_0102, 32'h8001_0000, 0, 32'hFFFF_8001);
        do_load(5'd9, 3'b101, 32'h0000_0102, 32'h8001_0000, 2, 32'h0000_8001);
        step();

        // SH with grant delayed 3 cycles
        do_store(3'b001, 32'h0000_0102, 32'h1234_ABCD, 3, 4'b1100, 32'hABCD_ABCD);
        do_store(3'b000, 32'h0000_0101, 32'h0000_00AB, 0, 4'b0010, 32'hABAB_ABAB);
        do_store(3'b010, 32'h0000_0104, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D);
        step();

        // Misaligned LW: no request, one-cycle fault pulse, no register write
        set_op(5'd10, 3'b010, 32'h0000_0101, 32'd0, 1'b1, 1'b0, 1'b1, 2'b01);
        push_exp(5'd10, 2'b01, 32'h0000_0101, 32'd0, 1'b0, 1'b1);
        #1;
        check_eq("mis_req", 32'(dbus_req), 32'd0);
        check_eq("mis_stall", 32'(mem_stall), 32'd0);
        step();
        idle_ex();
        check_eq("mis_pulse", 32'(mem_misaligned), 32'd1);
        step();
        check_eq("mis_one_cycle", 32'(mem_misaligned), 32'd0);

        // Reset while waiting for rvalid, then a late rvalid
        set_op(5'd11, 3'b010, 32'h0000_0200, 32'd0, 1'b1, 1'b0, 1'b1, 2'b01);
        dbus_gnt = 1'b1;
        step();
        dbus_gnt = 1'b0;
        #1;
        check_eq("rv_wait_stall", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rstmid_req", 32'(dbus_req), 32'd0);
        check_eq("rstmid_stall", 32'(mem_stall), 32'd0);
        check_eq("rstmid_wen", 32'(mem_regfile_wr_enable), 32'd0);
        check_eq("rstmid_rd", 32'(mem_rd), 32'd0);
        check_eq("rstmid_data", mem_read_data, 32'd0);
        idle_ex();
        step();
        rst         = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h5555_AAAA;
        #1;
        check_eq("late_rv_stall", 32'(mem_stall), 32'd0);
        check_eq("late_rv_req", 32'(dbus_req), 32'd0);
        step();
        dbus_rvalid = 1'b0;
        check_eq("late_rv_wen", 32'(mem_regfile_wr_enable), 32'd0);
        // ADD retires with latency 1
        set_op(5'd12, 3'b000, 32'h0000_0055, 32'd0, 1'b0, 1'b0, 1'b1, 2'b00);
        push_exp(5'd12, 2'b00, 32'h0000_0055, 32'd0, 1'b1, 1'b0);
        #1;
        check_eq("add_stall", 32'(mem_stall), 32'd0);
        step();
        idle_ex();
        check_eq("add_latency", 32'(mem_regfile_wr_enable), 32'd1);
        step();

        // Back-to-back SW then LW with immediate grant and rvalid
        set_op(5'd0, 3'b010, 32'h0000_0300, 32'h0BAD_CAFE, 1'b0, 1'b1, 1'b0, 2'b00);
        dbus_gnt = 1'b1;
        #1;
        check_eq("b2b_sw_req", 32'(dbus_req), 32'd1);
        check_eq("b2b_sw_stall", 32'(mem_stall), 32'd0);
        step();
        set_op(5'd13, 3'b010, 32'h0000_0304, 32'd0, 1'b1, 1'b0, 1'b1, 2'b01);
        push_exp(5'd13, 2'b01, 32'h0000_0304, 32'h1122_3344, 1'b1, 1'b0);
        #1;
        check_eq("b2b_lw_req", 32'(dbus_req), 32'd1);
        check_eq("b2b_lw_we", 32'(dbus_we), 32'd0);
        check_eq("b2b_lw_addr", dbus_addr, 32'h0000_0304);
        step();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h1122_3344;
        step();
        dbus_rvalid = 1'b0;
        idle_ex();
        step();
        step();

        check_eq("wb_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
